iface_inv_responder: RTL and testbench
======================================

// Module: iface_inv_responder
// PURPOSE
//   Responder end of the byte x/y interface. Accepts x bytes from the initiator over a
//   valid/ready handshake and buffers them in a small FIFO. Returns y = ~x over a second
//   valid/ready handshake, in order. Sits below the interface owner and is bound to its
//   x (in) and y (out) members; decouples initiator and consumer timing.
// PARAMETERS
//   DEPTH    4   FIFO entries; power of two, >= 2 (elaboration error otherwise)
//   CNT_W    16  width of optional response counter
// PORTS
//   clk      in   1          single clock, rising edge
//   rst_n    in   1          asynchronous assert, active-low reset
//   x_valid  in   1          initiator presents x
//   x_ready  out  1          responder can accept x this cycle
//   x        in   x_t (8)    request byte
//   y_valid  out  1          y holds a valid response
//   y_ready  in   1          consumer takes y this cycle
//   y        out  y_t (8)    response byte = ~x of oldest accepted request
//   level    out  clog2(DEPTH)+1  current FIFO occupancy
//   resp_cnt out  CNT_W      only when XY_RESP_CNT_EN defined
// BEHAVIOUR
//   Reset: one clock, asynchronous, active-low (rst_n). While rst_n=0: x_ready=0, y_valid=0,
//     y=8'h00, level=0, rd/wr pointers=0, resp_cnt=0. x_ready rises the first clk edge after
//     release.
//   Push: x_valid & x_ready at posedge -> mem[wr_ptr] <= ~x; wr_ptr++.
//   Pop: y_valid & y_ready at posedge -> rd_ptr++. y is driven from mem[rd_ptr]. y is
//     forced to 8'h00 when empty.
//   x_ready = (level != DEPTH); registered-state-derived, no combinational path from y_ready.
//   y_valid = (level != 0); no combinational path from x_valid (no bypass).
//   Latency: a byte accepted at edge N is visible on y with y_valid=1 after edge N.
//     Minimum 1 cycle.
//   Throughput: 1 byte/cycle sustained when both sides are continuously ready.
//   Simultaneous push+pop: level unchanged; both pointers advance. When full, push is
//     blocked by x_ready=0; pop-only applies. When empty, pop is impossible; push-only
//     applies.
//   Pointers: clog2(DEPTH) bits, natural wrap DEPTH-1 -> 0. level is held as a separate
//     counter, never exceeds DEPTH.
//   Holding: y and y_valid stay stable until popped. x_valid without x_ready is ignored;
//     the initiator holds.
//   Reset mid-operation: all stored entries are discarded immediately. No partial output.
//   Inversion: y is the bitwise NOT of x; no arithmetic; widths are always 8.
// CONFIGURATION
//   XY_RESP_CNT_EN defined: adds port resp_cnt[CNT_W-1:0].
//     - increments on every pop
//     - saturates at all-ones, does not wrap
//     - cleared by reset
//   XY_RESP_CNT_EN undefined: port and counter are absent. Behaviour is otherwise identical.
// STRUCTURE
//   Package xy_pkg:
//     - typedef logic [7:0] x_t; typedef logic [7:0] y_t
//     - localparam XY_W = 8
//     - function inv(x_t) -> y_t
//     Ports use xy_pkg::x_t / xy_pkg::y_t.
//   Sub-module xy_sync_fifo (DEPTH, data y_t):
//     - memory, pointers, level
//     - push/pop/full/empty
//   Top handles handshake mapping, inversion on write, and the optional counter.
// TESTING
//   1. rst_n=0 then release; x_valid=1 x=8'hA5 held -> x_ready=0 during reset; next cycle
//      push; y=8'h5A y_valid=1 one cycle later.
//   2. y_ready=0, push 8'h00,8'h01,8'h02,8'h03 -> level=4, x_ready=0. A 5th x=8'hFF is not
//      accepted. Raise y_ready -> y sequence FF,FE,FD,FC.
//   3. Full, x_valid=1 and y_ready=1 same cycle -> pop only; level 4->3; x_ready=1 next cycle.
//   4. Continuous x_valid=y_ready=1 over 10 bytes 8'h10..8'h19 -> y EF..E6, one per cycle
//      after the first; level stays at 1. Exercises pointer wrap.
//   5. level=3, assert rst_n=0 mid-burst asynchronously -> y_valid=0, level=0 immediately.
//      After release, no stale data appears.
//   6. XY_RESP_CNT_EN with CNT_W=2, pop 5 responses -> resp_cnt 1,2,3,3,3; undefined build
//      compiles without the port.

Source files
------------

// File: rtl/xy_pkg.sv
// Shared types and helpers for the byte x/y interface.
// x_t is the request byte, y_t the response byte; inv() maps one to the other.
package xy_pkg;

  localparam int XY_W = 8;

  typedef logic [XY_W-1:0] x_t;
  typedef logic [XY_W-1:0] y_t;

  // Response byte is the bitwise complement of the request byte.
  function automatic y_t inv(input x_t v);
    return y_t'(~v);
  endfunction

endpackage

// File: rtl/xy_sync_fifo.sv
// Small synchronous FIFO holding response bytes for the x/y responder.
// Occupancy is kept in its own counter so full and empty are unambiguous
// while the pointers simply wrap at DEPTH.
module xy_sync_fifo
  import xy_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type data_t = y_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  data_t                  wr_data,
  input  logic                   pop,
  output data_t                  rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

  // Pointer wrap relies on DEPTH being a power of two.
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("xy_sync_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  data_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/iface_inv_responder.sv
// Responder end of the byte x/y interface: buffers accepted x bytes and
// returns y = ~x in order over a second valid/ready handshake.
// Optional feature macro: XY_RESP_CNT_EN adds a saturating response counter
// on port resp_cnt.
module iface_inv_responder
  import xy_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   x_valid,
  output logic                   x_ready,
  input  x_t                     x,
  output logic                   y_valid,
  input  logic                   y_ready,
  output y_t                     y,
`ifdef XY_RESP_CNT_EN
  output logic [CNT_W-1:0]       resp_cnt,
`endif
  output logic [$clog2(DEPTH):0] level
);

  logic alive;
  logic full;
  logic empty;
  logic push;
  logic pop;
  y_t   rd_data;

  // Holds x_ready low through reset and lifts it on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  assign x_ready = alive & ~full;
  assign y_valid = ~empty;
  assign push    = x_valid & x_ready;
  assign pop     = y_valid & y_ready;
  assign y       = empty ? '0 : rd_data;

  xy_sync_fifo #(
    .DEPTH  (DEPTH),
    .data_t (y_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (inv(x)),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

`ifdef XY_RESP_CNT_EN
  // Counts delivered responses, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_cnt <= '0;
    end else if (pop && (resp_cnt != '1)) begin
      resp_cnt <= resp_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_iface_inv_responder.sv
// Testbench for iface_inv_responder: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
// Honours XY_RESP_CNT_EN to connect and check the response counter.
module tb_iface_inv_responder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             x_valid;
  logic             x_ready;
  logic [7:0]       x;
  logic             y_valid;
  logic             y_ready;
  logic [7:0]       y;
  logic [LVL_W-1:0] level;
`ifdef XY_RESP_CNT_EN
  logic [CNT_W-1:0] resp_cnt;
`endif

  int vectors;
  int miscompares;

  logic [7:0] model_q[$];
  bit         model_alive;
  int         model_cnt;

  iface_inv_responder #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .x        (x),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y        (y),
`ifdef XY_RESP_CNT_EN
    .resp_cnt (resp_cnt),
`endif
    .level    (level)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares every observable output against the reference model.
  task automatic checkOutput(input string tag);
    logic             exp_ready;
    logic             exp_valid;
    logic [7:0]       exp_y;
    logic [LVL_W-1:0] exp_level;
    exp_ready = model_alive && (model_q.size() < DEPTH);
    exp_valid = (model_q.size() != 0);
    exp_y     = (model_q.size() != 0) ? model_q[0] : 8'h00;
    exp_level = LVL_W'(model_q.size());
    vectors++;
    assert (x_ready === exp_ready) else begin
      miscompares++;
      $error("[TB] FAIL %s x_ready got %b want %b", tag, x_ready, exp_ready);
    end
    vectors++;
    assert (y_valid === exp_valid) else begin
      miscompares++;
      $error("[TB] FAIL %s y_valid got %b want %b", tag, y_valid, exp_valid);
    end
    vectors++;
    assert (y === exp_y) else begin
      miscompares++;
      $error("[TB] FAIL %s y got %h want %h", tag, y, exp_y);
    end
    vectors++;
    assert (level === exp_level) else begin
      miscompares++;
      $error("[TB] FAIL %s level got %0d want %0d", tag, level, exp_level);
    end
`ifdef XY_RESP_CNT_EN
    vectors++;
    assert (resp_cnt === CNT_W'(model_cnt)) else begin
      miscompares++;
      $error("[TB] FAIL %s resp_cnt got %0d want %0d", tag, resp_cnt, model_cnt);
    end
`endif
  endtask

  // Drives one cycle of inputs, advances the model at the edge, then checks.
  task automatic applyStimulus(input logic xv, input logic [7:0] xd,
                               input logic yr, input string tag);
    bit do_push;
    bit do_pop;
    x_valid = xv;
    x       = xd;
    y_ready = yr;
    @(posedge clk);
    do_push = xv && model_alive && (model_q.size() < DEPTH);
    do_pop  = yr && (model_q.size() != 0);
    if (do_pop) begin
      void'(model_q.pop_front());
      if (model_cnt < (1 << CNT_W) - 1) model_cnt++;
    end
    if (do_push) model_q.push_back(~xd);
    model_alive = 1'b1;
    #1;
    checkOutput(tag);
  endtask

  // Asserts reset away from the clock edge and checks outputs clear at once.
  task automatic asyncReset(input string tag);
    #2;
    rst_n = 1'b0;
    model_q.delete();
    model_alive = 1'b0;
    model_cnt   = 0;
    #1;
    checkOutput(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_alive = 1'b0;
    model_cnt   = 0;
    rst_n       = 1'b0;
    x_valid     = 1'b1;
    x           = 8'hA5;
    y_ready     = 1'b0;

    // Reset with a request already waiting.
    #12;
    checkOutput("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("just_released");
    applyStimulus(1'b1, 8'hA5, 1'b0, "first_edge");
    applyStimulus(1'b1, 8'hA5, 1'b0, "first_push");
    applyStimulus(1'b0, 8'h00, 1'b1, "drain_a5");

    // Fill with the consumer stalled, then attempt an overflow.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(i), 1'b0, "fill");
    applyStimulus(1'b1, 8'hFF, 1'b0, "overflow_blocked");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, "drain_seq");

    // Full with both sides active: pop only.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h30 + 8'(i), 1'b0, "refill");
    applyStimulus(1'b1, 8'h77, 1'b1, "full_pop_only");
    applyStimulus(1'b0, 8'h00, 1'b0, "after_full_pop");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, "drain_full");

    // Streaming at one byte per cycle across pointer wrap.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 1'b1, "stream");
    applyStimulus(1'b0, 8'h00, 1'b1, "stream_tail");

    // Reset in the middle of a burst discards stored bytes.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, "pre_reset");
    asyncReset("mid_reset");
    applyStimulus(1'b0, 8'h00, 1'b1, "post_reset_a");
    applyStimulus(1'b0, 8'h00, 1'b1, "post_reset_b");

    // Counter saturation: five responses in a row.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h50 + 8'(i), 1'b1, "cnt_stream");
    applyStimulus(1'b0, 8'h00, 1'b1, "cnt_tail");

    // Random traffic on both handshakes.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                    "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
